// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU and an external port.
// Every grant runs IDLE -> ACCESS -> WAIT -> DONE; WAIT lasts MEM_LAT cycles.
module dmem_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic [DATA_W-1:0] ext_rdata,
   output logic              ext_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;
   typedef enum logic {PORT_CPU, PORT_EXT} port_t;

   state_t            state, next_state;
   port_t             owner, last, grant;
   logic [CNT_W-1:0]  cnt;
   logic              is_write;
   logic              lat_done;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   assign lat_done = (cnt == CNT_W'(1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      // NOTE: default assignment first, so no path leaves next_state unassigned and no latch appears.
      next_state = state;
      case (state)
         S_IDLE:   if (cpu_req || ext_req) next_state = S_ACCESS;
         S_ACCESS: next_state = S_WAIT;
         S_WAIT:   if (lat_done) next_state = S_DONE;
         S_DONE:   next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // On a tie the port that was not served last wins, so grants alternate under contention.
   always_comb begin
      if (cpu_req && ext_req) grant = (last == PORT_CPU) ? PORT_EXT : PORT_CPU;
      else if (ext_req)       grant = PORT_EXT;
      else                    grant = PORT_CPU;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner     <= PORT_CPU;
         last      <= PORT_EXT;
         cnt       <= '0;
         is_write  <= 1'b0;
         cpu_rdata <= '0;
         ext_rdata <= '0;
      end else begin
         case (state)
            S_IDLE: if (cpu_req || ext_req) owner <= grant;
            S_ACCESS: begin
               cnt      <= CNT_W'(MEM_LAT);
               is_write <= sel_we;
            end
            S_WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (lat_done) begin
                  last <= owner;
                  if (!is_write) begin
                     if (owner == PORT_CPU) cpu_rdata <= mem_rdata;
                     else                   ext_rdata <= mem_rdata;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      sel_we    = (owner == PORT_CPU) ? cpu_we    : ext_we;
      sel_addr  = (owner == PORT_CPU) ? cpu_addr  : ext_addr;
      sel_wdata = (owner == PORT_CPU) ? cpu_wdata : ext_wdata;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_ack   = 1'b0;
      ext_ack   = 1'b0;
      case (state)
         S_ACCESS: begin
            mem_en    = 1'b1;
            mem_we    = sel_we;
            mem_addr  = sel_addr;
            mem_wdata = sel_wdata;
         end
         S_DONE: begin
            cpu_ack = (owner == PORT_CPU);
            ext_ack = (owner == PORT_EXT);
         end
         default: ;
      endcase
   end

   assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table and corner sequences, then random traffic on
// MEM_LAT=1 and MEM_LAT=3 instances against a transaction-level reference model.
module tb_dmem_arbiter;

   localparam int NI = 2;

   logic clk;
   logic load_mem;
   logic [NI-1:0]       rst, cpu_req, cpu_we, ext_req, ext_we;
   logic [NI-1:0]       cpu_ack, ext_ack, cpu_stall, mem_en, mem_we;
   logic [NI-1:0][7:0]  cpu_addr, ext_addr, mem_addr;
   logic [NI-1:0][31:0] cpu_wdata, ext_wdata, cpu_rdata, ext_rdata, mem_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int a);
      return 32'(a + 1);
   endfunction

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   // Memory model: writes land on the sample edge, read data appears MEM_LAT edges later.
   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : 3;
      logic [31:0] mem [256];
      logic [31:0] pipe [L];
      logic [31:0] rdata;

      dmem_arbiter #(.DATA_W(32), .ADDR_W(8), .MEM_LAT(L)) dut (
         .clk(clk), .reset(rst[g]),
         .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
         .cpu_wdata(cpu_wdata[g]), .cpu_rdata(cpu_rdata[g]), .cpu_ack(cpu_ack[g]),
         .cpu_stall(cpu_stall[g]),
         .ext_req(ext_req[g]), .ext_we(ext_we[g]), .ext_addr(ext_addr[g]),
         .ext_wdata(ext_wdata[g]), .ext_rdata(ext_rdata[g]), .ext_ack(ext_ack[g]),
         .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
         .mem_wdata(mem_wdata[g]), .mem_rdata(rdata)
      );

      always @(posedge clk) begin
         if (load_mem) begin
            for (int a = 0; a < 256; a++) mem[a] <= init_word(a);
         end else if (mem_en[g] && mem_we[g]) begin
            mem[mem_addr[g]] <= mem_wdata[g];
         end
         pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 32'hbad0_0bad;
         for (int s = 1; s < L; s++) pipe[s] <= pipe[s-1];
      end
      assign rdata = pipe[L-1];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst, cr, cw, er, ew;
      logic [7:0]  ca, ea;
      logic [31:0] cd, ed;
      logic        en, we, cack, eack, stall;
      logic [7:0]  addr;
      logic [31:0] wd, crd, erd;
   } vec_t;

   function automatic vec_t mk(
      input logic [31:0] r, cr, cw, ca, cd, er, ew, ea, ed,
      input logic [31:0] en, we, addr, wd, cack, eack, stall, crd, erd);
      vec_t v;
      v.rst = r[0];   v.cr = cr[0];   v.cw = cw[0];   v.ca = ca[7:0];   v.cd = cd;
      v.er = er[0];   v.ew = ew[0];   v.ea = ea[7:0]; v.ed = ed;
      v.en = en[0];   v.we = we[0];   v.addr = addr[7:0]; v.wd = wd;
      v.cack = cack[0]; v.eack = eack[0]; v.stall = stall[0]; v.crd = crd; v.erd = erd;
      return v;
   endfunction

   // Reference model: transaction phase counted as cycles since the grant edge.
   bit          m_busy [NI];
   int          m_t    [NI];
   bit          m_owner[NI];
   bit          m_last [NI];
   bit          m_we   [NI];
   logic [7:0]  m_addr [NI];
   logic [31:0] m_wdata[NI];
   logic [31:0] m_read [NI];
   logic [31:0] m_rdata[NI][2];
   logic [31:0] ref_mem[NI][256];
   logic [1:0]  ack_hist[NI][2];

   task automatic model_step(input int i);
      int L = lat_of(i);
      if (m_busy[i] && m_t[i] == 1) begin
         if (m_we[i]) ref_mem[i][m_addr[i]] = m_wdata[i];
         else         m_read[i] = ref_mem[i][m_addr[i]];
      end
      if (rst[i]) begin
         m_busy[i] = 0;
         m_last[i] = 1;
         m_rdata[i][0] = '0;
         m_rdata[i][1] = '0;
         return;
      end
      if (m_busy[i]) begin
         if (m_t[i] == L + 1) begin
            if (!m_we[i]) m_rdata[i][m_owner[i]] = m_read[i];
            m_last[i] = m_owner[i];
         end
         if (m_t[i] == L + 2) m_busy[i] = 0;
         else                 m_t[i]++;
      end else if (cpu_req[i] || ext_req[i]) begin
         m_owner[i] = (cpu_req[i] && ext_req[i]) ? !m_last[i] : ext_req[i];
         m_we[i]    = m_owner[i] ? ext_we[i]    : cpu_we[i];
         m_addr[i]  = m_owner[i] ? ext_addr[i]  : cpu_addr[i];
         m_wdata[i] = m_owner[i] ? ext_wdata[i] : cpu_wdata[i];
         m_busy[i]  = 1;
         m_t[i]     = 1;
      end
   endtask

   task automatic model_compare(input int i);
      int   L  = lat_of(i);
      logic en = m_busy[i] && m_t[i] == 1;
      logic ca = m_busy[i] && m_t[i] == L + 2 && !m_owner[i];
      logic ea = m_busy[i] && m_t[i] == L + 2 && m_owner[i];
      check($sformatf("r%0d_mem_en", i), mem_en[i], en);
      check($sformatf("r%0d_mem_we", i), mem_we[i], en && m_we[i]);
      check($sformatf("r%0d_mem_addr", i), mem_addr[i], en ? m_addr[i] : 8'h0);
      check($sformatf("r%0d_mem_wdata", i), mem_wdata[i], en ? m_wdata[i] : 32'h0);
      check($sformatf("r%0d_cpu_ack", i), cpu_ack[i], ca);
      check($sformatf("r%0d_ext_ack", i), ext_ack[i], ea);
      check($sformatf("r%0d_cpu_rdata", i), cpu_rdata[i], m_rdata[i][0]);
      check($sformatf("r%0d_ext_rdata", i), ext_rdata[i], m_rdata[i][1]);
      check($sformatf("r%0d_cpu_stall", i), cpu_stall[i], cpu_req[i] && !ca);
   endtask

   // Random requester: holds fields until ack, reacts to ack at the edge after seeing it.
   task automatic rand_port(input int i, input int p);
      logic r = (p == 0) ? cpu_req[i] : ext_req[i];
      bit issue = 0;
      bit drop  = 0;
      if (r && ack_hist[i][p][1]) begin
         if ($urandom_range(0, 1) == 1) issue = 1;
         else                           drop  = 1;
      end else if (!r && $urandom_range(0, 2) == 0) begin
         issue = 1;
      end
      if (p == 0) begin
         if (issue) begin
            cpu_req[i] = 1'b1; cpu_we[i] = 1'($urandom_range(0, 1));
            cpu_addr[i] = 8'($urandom_range(0, 15)); cpu_wdata[i] = $urandom;
         end else if (drop) cpu_req[i] = 1'b0;
      end else begin
         if (issue) begin
            ext_req[i] = 1'b1; ext_we[i] = 1'($urandom_range(0, 1));
            ext_addr[i] = 8'($urandom_range(0, 15)); ext_wdata[i] = $urandom;
         end else if (drop) ext_req[i] = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the summary in time");
      $fatal(1);
   end

   initial begin
      vec_t tv[15];
      int   order[6];
      int   n, both, en_cnt;
      logic [31:0] D = 32'hdeadbeef;

      rst = '1; load_mem = 1'b1;
      cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
      ext_req = '0; ext_we = '0; ext_addr = '0; ext_wdata = '0;
      @(posedge clk); #1;
      load_mem = 1'b0;

      //          rst cr cw ca cd  er ew ea ed  en we ad wd  ca ea st crd erd
      tv[0]  = mk(1,  1, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0);
      tv[1]  = mk(1,  1, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0);
      tv[2]  = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0);
      tv[3]  = mk(0,  1, 0, 2, 0,  0, 0, 0, 0,  1, 0, 2, 0,  0, 0, 1, 0, 0);
      tv[4]  = mk(0,  1, 0, 2, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0);
      tv[5]  = mk(0,  1, 0, 2, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 3, 0);
      tv[6]  = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 3, 0);
      tv[7]  = mk(0,  0, 0, 0, 0,  1, 1, 5, D,  1, 1, 5, D,  0, 0, 0, 3, 0);
      tv[8]  = mk(0,  0, 0, 0, 0,  1, 1, 5, D,  0, 0, 0, 0,  0, 0, 0, 3, 0);
      tv[9]  = mk(0,  0, 0, 0, 0,  1, 1, 5, D,  0, 0, 0, 0,  0, 1, 0, 3, 0);
      tv[10] = mk(0,  1, 0, 5, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 3, 0);
      tv[11] = mk(0,  1, 0, 5, 0,  0, 0, 0, 0,  1, 0, 5, 0,  0, 0, 1, 3, 0);
      tv[12] = mk(0,  1, 0, 5, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 3, 0);
      tv[13] = mk(0,  1, 0, 5, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0, D, 0);
      tv[14] = mk(0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, D, 0);

      for (int k = 0; k < 15; k++) begin
         rst[0] = tv[k].rst;
         cpu_req[0] = tv[k].cr; cpu_we[0] = tv[k].cw; cpu_addr[0] = tv[k].ca; cpu_wdata[0] = tv[k].cd;
         ext_req[0] = tv[k].er; ext_we[0] = tv[k].ew; ext_addr[0] = tv[k].ea; ext_wdata[0] = tv[k].ed;
         @(posedge clk); #1;
         check($sformatf("v%0d_mem_en", k), mem_en[0], tv[k].en);
         check($sformatf("v%0d_mem_we", k), mem_we[0], tv[k].we);
         check($sformatf("v%0d_mem_addr", k), mem_addr[0], tv[k].addr);
         check($sformatf("v%0d_mem_wdata", k), mem_wdata[0], tv[k].wd);
         check($sformatf("v%0d_cpu_ack", k), cpu_ack[0], tv[k].cack);
         check($sformatf("v%0d_ext_ack", k), ext_ack[0], tv[k].eack);
         check($sformatf("v%0d_cpu_stall", k), cpu_stall[0], tv[k].stall);
         check($sformatf("v%0d_cpu_rdata", k), cpu_rdata[0], tv[k].crd);
         check($sformatf("v%0d_ext_rdata", k), ext_rdata[0], tv[k].erd);
      end

      // Both ports requesting from reset: grants must alternate starting with the CPU.
      rst[0] = 1'b1;
      cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 8'd3;
      ext_req[0] = 1'b1; ext_we[0] = 1'b0; ext_addr[0] = 8'd4;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      n = 0; both = 0;
      for (int c = 0; c < 60 && n < 6; c++) begin
         @(posedge clk); #1;
         if (cpu_ack[0] && ext_ack[0]) both++;
         if (cpu_ack[0] && n < 6) begin order[n] = 0; n++; end
         if (ext_ack[0] && n < 6) begin order[n] = 1; n++; end
      end
      check("alt_count", n, 6);
      check("alt_both_ack", both, 0);
      for (int k = 0; k < n; k++) check($sformatf("alt_order%0d", k), order[k], k % 2);
      check("alt_cpu_rdata", cpu_rdata[0], 32'h4);
      check("alt_ext_rdata", ext_rdata[0], 32'h5);
      cpu_req[0] = 1'b0; ext_req[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset while a CPU read is waiting on memory, then the same read reissued.
      cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 8'd2;
      @(posedge clk); #1;
      check("rw_access_en", mem_en[0], 1'b1);
      @(posedge clk); #1;
      check("rw_wait_en", mem_en[0], 1'b0);
      rst[0] = 1'b1;
      @(posedge clk); #1;
      check("rw_rst_ack", cpu_ack[0], 1'b0);
      check("rw_rst_rdata", cpu_rdata[0], 32'h0);
      check("rw_rst_en", mem_en[0], 1'b0);
      rst[0] = 1'b0;
      n = 0;
      for (int c = 1; c <= 10 && n == 0; c++) begin
         @(posedge clk); #1;
         if (cpu_ack[0]) n = c;
      end
      check("rw_reissue_latency", n, 3);
      check("rw_reissue_rdata", cpu_rdata[0], 32'h3);
      cpu_req[0] = 1'b0;
      @(posedge clk); #1;

      // MEM_LAT=3 instance: external read of address 1.
      rst[1] = 1'b0;
      ext_req[1] = 1'b1; ext_we[1] = 1'b0; ext_addr[1] = 8'd1;
      n = 0; en_cnt = 0;
      for (int c = 1; c <= 20 && n == 0; c++) begin
         @(posedge clk); #1;
         if (mem_en[1]) en_cnt++;
         if (ext_ack[1]) n = c;
      end
      check("l3_latency", n, 5);
      check("l3_mem_en_cycles", en_cnt, 1);
      check("l3_ext_rdata", ext_rdata[1], 32'h2);
      check("l3_cpu_rdata", cpu_rdata[1], 32'h0);
      ext_req[1] = 1'b0;
      @(posedge clk); #1;

      // Random traffic on both instances against the reference model.
      rst = '1; load_mem = 1'b1;
      cpu_req = '0; ext_req = '0;
      for (int i = 0; i < NI; i++) begin
         m_busy[i] = 0; m_t[i] = 0; m_last[i] = 1; m_owner[i] = 0;
         m_rdata[i][0] = '0; m_rdata[i][1] = '0; m_read[i] = '0;
         ack_hist[i][0] = '0; ack_hist[i][1] = '0;
         for (int a = 0; a < 256; a++) ref_mem[i][a] = init_word(a);
      end
      @(posedge clk); #1;
      load_mem = 1'b0;
      rst = '0;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NI; i++) begin
            rst[i] = ($urandom_range(0, 199) == 0);
            rand_port(i, 0);
            rand_port(i, 1);
            model_step(i);
         end
         @(posedge clk); #1;
         for (int i = 0; i < NI; i++) begin
            model_compare(i);
            ack_hist[i][0] = {ack_hist[i][0][0], cpu_ack[i]};
            ack_hist[i][1] = {ack_hist[i][1][0], ext_ack[i]};
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
